// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - architectural register file with write bypass and busy scoreboard
module reg_file_sb #(
    parameter int                NUM_REGS = 20,
    parameter int                DATA_W   = 64,
    parameter int                FLAG_W   = 6,
    parameter int                NUM_RD   = 2,
    parameter int                NUM_WR   = 2,
    parameter int                IDX_W    = 5,
    parameter int                SP_IDX   = 4,
    parameter logic [DATA_W-1:0] SP_INIT  = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD*FLAG_W-1:0]   rd_flags,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*IDX_W-1:0]    wr_idx,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR*FLAG_W-1:0]   wr_flags,
    input  logic [NUM_WR-1:0]          wr_flags_en,
    input  logic [NUM_WR-1:0]          wr_clr_busy,
    input  logic                       rsv_en,
    input  logic [IDX_W-1:0]           rsv_idx,
    output logic                       rsv_ready,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic                       err_oob
);

    logic [DATA_W-1:0]   val_q [NUM_REGS];
    logic [FLAG_W-1:0]   flg_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic                err_q;

    // Per-entry winning write: the highest-numbered port hitting the entry.
    logic [NUM_REGS-1:0] w_hit;
    logic [NUM_REGS-1:0] w_fen;
    logic [NUM_REGS-1:0] w_clr;
    logic [DATA_W-1:0]   w_data  [NUM_REGS];
    logic [FLAG_W-1:0]   w_flags [NUM_REGS];

    logic rsv_acc;
    logic err_d;

    function automatic logic is_oob(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} >= (IDX_W+1)'(NUM_REGS);
    endfunction

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_hit[r]   = 1'b0;
            w_fen[r]   = 1'b0;
            w_clr[r]   = 1'b0;
            w_data[r]  = '0;
            w_flags[r] = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && wr_idx[i*IDX_W +: IDX_W] == IDX_W'(r)) begin
                    w_hit[r]   = 1'b1;
                    w_fen[r]   = wr_flags_en[i];
                    w_clr[r]   = wr_clr_busy[i];
                    w_data[r]  = wr_data[i*DATA_W +: DATA_W];
                    w_flags[r] = wr_flags[i*FLAG_W +: FLAG_W];
                end
            end
        end
    end

    // Reads decode the index against each valid entry, so out-of-range indices fall through to zero.
    always_comb begin
        rd_data  = '0;
        rd_flags = '0;
        rd_busy  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_idx[p*IDX_W +: IDX_W] == IDX_W'(r)) begin
                    rd_data[p*DATA_W +: DATA_W]  = w_hit[r] ? w_data[r] : val_q[r];
                    rd_flags[p*FLAG_W +: FLAG_W] = (w_hit[r] && w_fen[r]) ? w_flags[r] : flg_q[r];
                    rd_busy[p]                   = busy_q[r] & ~(w_hit[r] & w_clr[r]);
                end
            end
        end
    end

    always_comb begin
        rsv_ready = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rsv_idx == IDX_W'(r)) begin
                rsv_ready = ~busy_q[r] | (w_hit[r] & w_clr[r]);
            end
        end
    end

    assign rsv_acc = rsv_en & rsv_ready;

    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && is_oob(wr_idx[i*IDX_W +: IDX_W])) begin
                err_d = 1'b1;
            end
        end
        if (rsv_en && is_oob(rsv_idx)) begin
            err_d = 1'b1;
        end
    end

    // A reservation landing with a clear keeps the entry busy for the new producer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
                flg_q[r] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_hit[r]) begin
                    val_q[r] <= w_data[r];
                end
                if (w_hit[r] && w_fen[r]) begin
                    flg_q[r] <= w_flags[r];
                end
                if (rsv_acc && rsv_idx == IDX_W'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if (w_hit[r] && w_clr[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
            err_q <= err_d;
        end
    end

    assign busy_vec = busy_q;
    assign err_oob  = err_q;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised architectural register file with a per-register busy scoreboard for the x86-64 core. Successor to the fixed 20-entry register-value package.
- Each entry holds a 64-bit value plus six status flags (cf, zf, sf, of, pf, af).
- Provides N combinational read ports with write bypass, M write ports with port priority, and a reserve/ready handshake that tracks in-flight producers.
- Sits between decode/issue (reads, reservations) and writeback (writes, busy clears).

Parameters:
NUM_REGS, 20, number of entries (rax..r15, rflags, rha, rhb, rhc at indices 0..19)
DATA_W, 64, value width
FLAG_W, 6, flag width; bit order MSB..LSB = cf, zf, sf, of, pf, af
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
IDX_W, 5, index width; must satisfy 2**IDX_W >= NUM_REGS
SP_IDX, 4, index of the stack pointer entry
SP_INIT, 64'h0, reset value of entry SP_IDX

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rd_idx  in  NUM_RD*IDX_W  read indices, port p in slice p
rd_data  out  NUM_RD*DATA_W  read values
rd_flags  out  NUM_RD*FLAG_W  read flags
rd_busy  out  NUM_RD  busy status of the read entry
wr_en  in  NUM_WR  write strobes
wr_idx  in  NUM_WR*IDX_W  write indices
wr_data  in  NUM_WR*DATA_W  write values
wr_flags  in  NUM_WR*FLAG_W  write flags
wr_flags_en  in  NUM_WR  when 1, the write also updates flags
wr_clr_busy  in  NUM_WR  when 1, the write also clears the entry's busy bit
rsv_en  in  1  reservation request
rsv_idx  in  IDX_W  entry to reserve
rsv_ready  out  1  reservation can be accepted this cycle
busy_vec  out  NUM_REGS  registered busy bits
err_oob  out  1  one-cycle pulse after any out-of-range index use

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All values and flags are 0, except value[SP_IDX] = SP_INIT.
  - busy_vec = 0, err_oob = 0.
  - Reset mid-operation discards all pending reservations.
- Write (registered):
  - On a rising edge, each wr_en[i] with wr_idx[i] < NUM_REGS updates the value.
  - Flags are updated only if wr_flags_en[i]; otherwise the old flags are kept.
  - If several ports target the same index, the highest-numbered port wins for value, flags and clear.
- Read (combinational, zero latency):
  - rd_data/rd_flags return the stored entry.
  - Bypass: if any active write targets the same index this cycle, the read returns the winning port's wr_data. Flags are bypassed only if that port's wr_flags_en is set.
  - rd_idx >= NUM_REGS returns 0 data, 0 flags, rd_busy = 0.
- Scoreboard:
  - rd_busy[p] = busy[rd_idx[p]] AND NOT (a winning write with wr_clr_busy targets that index this cycle).
  - rsv_ready = rsv_idx < NUM_REGS AND (busy[rsv_idx] = 0 OR a winning clearing write targets rsv_idx this cycle).
  - Reservation is accepted when rsv_en & rsv_ready; busy[rsv_idx] is set at the next edge.
  - Accepted reservation and clear on the same index in the same cycle: the reservation wins, and busy stays 1 (new producer).
  - rsv_en with rsv_ready = 0 has no effect; the requester holds the request.
  - A newly set busy bit is not visible on rd_busy until the following cycle (no reserve bypass).
  - wr_clr_busy on a non-busy entry has no effect.
- Errors: err_oob is registered. It is 1 for exactly one cycle after any active wr_en, or any rsv_en, with index >= NUM_REGS. Out-of-range reads do not raise err_oob. Out-of-range writes and reservations are dropped.
- No internal read of indices NUM_REGS..2**IDX_W-1 is ever performed (guard all array accesses).

Test Plan:
- Reset with SP_INIT=64'h7FFF_0000 → read port 0 idx 4 returns 64'h7FFF_0000; idx 0 returns 0; busy_vec=0.
- Same-cycle write port0 idx2=64'hAA, port1 idx2=64'hBB with flags_en, flags=6'b100001 → bypassed read gives 64'hBB / 6'b100001; after the edge, stored value is 64'hBB.
- Write idx 16 with wr_flags_en=0, flags=6'h3F → stored flags unchanged (0), value updated.
- rsv idx3 accepted → busy_vec[3]=1 next cycle; second rsv idx3 sees rsv_ready=0; writeback idx3 with clr and rsv idx3 in the same cycle → rsv_ready=1, busy_vec[3] remains 1.
- wr_en idx 25 with NUM_REGS=20 → no state change; err_oob=1 for one cycle. Read idx 25 → data 0, no error.
- Assert reset_n low mid-sequence with busy_vec=20'h0000F → busy_vec=0 and values cleared immediately, without waiting for a clock edge.
